// File: rtl/rr_decode_arbiter.sv
// 16-requester round-robin arbiter with hold-until-release ownership,
// optional max-hold preemption and a global enable gating new grants.
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid,
    output logic        preempt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nx;
    logic [3:0]       ptr, ptr_nx;
    logic [3:0]       idx_nx;
    logic             valid_nx;
    logic             preempt_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic [15:0]      others;
    logic [3:0]       cand;
    logic             owner_req;
    logic             timed_out;

    // First requester strictly after p, wrapping; p itself is only reached last.
    function automatic logic [3:0] rr_next(input logic [3:0] p, input logic [15:0] r);
        logic [3:0] idx;
        logic       found;
        rr_next = p;
        found   = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = p + 4'(k);
            if (!found && r[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // In GRANT the owner is masked out so it can never hand off to itself.
    assign others    = (state == GRANT) ? (req & ~gnt) : req;
    assign cand      = rr_next(ptr, others);
    assign owner_req = req[gnt_idx];
    assign timed_out = (MAX_HOLD != 0) && (cnt >= CNT_W'(MAX_HOLD));

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        idx_nx     = gnt_idx;
        valid_nx   = gnt_valid;
        preempt_nx = 1'b0;
        cnt_nx     = cnt;

        unique case (state)
            IDLE: begin
                if (en && (req != 16'd0)) begin
                    state_nx = GRANT;
                    idx_nx   = cand;
                    ptr_nx   = cand;
                    valid_nx = 1'b1;
                    cnt_nx   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!owner_req || timed_out) begin
                    if (en && (others != 16'd0)) begin
                        idx_nx     = cand;
                        ptr_nx     = cand;
                        cnt_nx     = CNT_W'(1);
                        preempt_nx = owner_req;
                    end else if (!owner_req) begin
                        state_nx = IDLE;
                        idx_nx   = 4'd0;
                        valid_nx = 1'b0;
                        cnt_nx   = '0;
                    end
                end else if (cnt != {CNT_W{1'b1}}) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = 4'd0;
                valid_nx = 1'b0;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 4'd15;
            gnt_idx   <= 4'd0;
            gnt_valid <= 1'b0;
            gnt       <= 16'd0;
            preempt   <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
            gnt       <= valid_nx ? (16'd1 << idx_nx) : 16'd0;
            preempt   <= preempt_nx;
            cnt       <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed testbench for rr_decode_arbiter with hand-computed grant sequences.
module tb_rr_decode_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        preempt;

    int checkCount;
    int failCount;

    rr_decode_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expectGrant(input string tag, input logic valid, input logic [3:0] idx, input logic pre);
        logic [15:0] expGnt;
        logic [3:0]  expIdx;
        expIdx = valid ? idx : 4'd0;
        expGnt = valid ? (16'd1 << idx) : 16'd0;
        checkOutput({tag, ".gnt"},       32'(gnt),       32'(expGnt));
        checkOutput({tag, ".gnt_idx"},   32'(gnt_idx),   32'(expIdx));
        checkOutput({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(valid));
        checkOutput({tag, ".preempt"},   32'(preempt),   32'(pre));
    endtask

    task automatic applyStimulus(input logic stimEn, input logic [15:0] stimReq);
        en  = stimEn;
        req = stimReq;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int cycles);
        rst = 1'b1;
        en  = 1'b1;
        req = 16'd0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        en  = 1'b1;
        req = 16'd0;

        // Basic grant and release
        applyReset(2);
        expectGrant("reset", 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 16'h0001);
        expectGrant("basic_grant", 1'b1, 4'd0, 1'b0);
        applyStimulus(1'b1, 16'h0000);
        expectGrant("basic_release", 1'b0, 4'd0, 1'b0);

        // Handoff without idle cycle, then wrap from ptr=15
        applyReset(1);
        applyStimulus(1'b1, 16'h8001);
        expectGrant("wrap_first", 1'b1, 4'd0, 1'b0);
        applyStimulus(1'b1, 16'h8000);
        expectGrant("handoff_15", 1'b1, 4'd15, 1'b0);
        applyStimulus(1'b1, 16'h0000);
        expectGrant("handoff_idle", 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 16'h8001);
        expectGrant("wrap_to_0", 1'b1, 4'd0, 1'b0);

        // Timeout rotation between requesters 1 and 2
        applyReset(1);
        for (int c = 1; c <= 34; c++) begin
            logic [3:0] expIdx;
            logic       expPre;
            expIdx = (((c - 1) / 8) % 2 == 0) ? 4'd1 : 4'd2;
            expPre = (c > 8) && ((c - 1) % 8 == 0);
            applyStimulus(1'b1, 16'h0006);
            expectGrant($sformatf("rotate_c%0d", c), 1'b1, expIdx, expPre);
        end

        // Uncontended hold, then late competitor preempts
        applyReset(1);
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(1'b1, 16'h0010);
            expectGrant($sformatf("hold_c%0d", c), 1'b1, 4'd4, 1'b0);
        end
        applyStimulus(1'b1, 16'h0011);
        expectGrant("late_preempt", 1'b1, 4'd0, 1'b1);
        applyStimulus(1'b1, 16'h0011);
        expectGrant("late_preempt_hold", 1'b1, 4'd0, 1'b0);
        applyStimulus(1'b1, 16'h0000);
        expectGrant("late_release", 1'b0, 4'd0, 1'b0);

        // Enable gating
        applyReset(1);
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(1'b0, 16'hFFFF);
            expectGrant($sformatf("en_off_c%0d", c), 1'b0, 4'd0, 1'b0);
        end
        applyStimulus(1'b1, 16'hFFFF);
        expectGrant("en_on", 1'b1, 4'd0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(1'b0, 16'hFFFF);
            expectGrant($sformatf("en_hold_c%0d", c), 1'b1, 4'd0, 1'b0);
        end
        applyStimulus(1'b0, 16'hFFFE);
        expectGrant("en_off_release", 1'b0, 4'd0, 1'b0);

        // Reset in the middle of a grant
        applyReset(1);
        applyStimulus(1'b1, 16'h0020);
        expectGrant("mid_grant5", 1'b1, 4'd5, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 16'h0020);
        expectGrant("mid_reset", 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 16'h0003);
        expectGrant("mid_after", 1'b1, 4'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- 16-requester round-robin arbiter. Shares one 16-way resource whose select lines come from a 4-to-16 one-hot decoder.
- Registers the winning 4-bit index and its one-hot decode. A downstream decoder or the gnt bus can drive the resource selects directly.
- Adds hold-until-release ownership, an optional max-hold timeout with preemption, and a global enable.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles for one owner while others wait. 0 disables the timeout.
- CNT_W, 4, hold-counter width. Must satisfy 2^CNT_W - 1 >= MAX_HOLD.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  arbitration enable; gates new grants and handoffs
- req  input  16  request vector, req[i] = requester i wants the resource
- gnt  output  16  registered one-hot grant, gnt[i] = requester i owns the resource
- gnt_idx  output  4  registered binary index of the current owner
- gnt_valid  output  1  registered, 1 when a grant is active
- preempt  output  1  registered one-cycle pulse, high in the first cycle of a grant produced by timeout

Behaviour:
- Reset (rst=1 at a rising edge, including mid-grant):
  - gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, hold cnt=0.
  - Last-owner pointer ptr=15, so the first search starts at index 0.
  - State=IDLE. rst has priority over all other inputs.
- Invariant: gnt == (gnt_valid ? 1<<gnt_idx : 0) on every cycle.
- Search function next(p):
  - Scan indices (p+1) mod 16, (p+2) mod 16, ... with wrap-around.
  - Return the first index whose req bit is set.
  - The current owner is excluded when called from GRANT.
- State IDLE:
  - If en=1 and req!=0: next edge go to GRANT with gnt_idx=next(ptr), ptr=gnt_idx, cnt=1, gnt_valid=1.
  - Otherwise stay IDLE with outputs at zero.
  - Latency from request to grant: 1 cycle.
- State GRANT, owner o:
  - Release (req[o]=0):
    - If en=1 and another request is pending: hand off in the next edge to next(o), with ptr updated, cnt=1, and no idle cycle.
    - Otherwise return to IDLE (gnt_valid=0).
  - Hold (req[o]=1, and MAX_HOLD=0 or cnt<MAX_HOLD): keep owner; cnt<=cnt+1, saturating at 2^CNT_W-1.
  - Timeout (req[o]=1, MAX_HOLD>0, cnt==MAX_HOLD):
    - If en=1 and another request is pending: hand off to next(o), cnt=1, preempt=1 for exactly that first cycle.
    - If no other request is pending or en=0: keep owner, cnt holds at MAX_HOLD, no preempt.
    - A later arrival of a competing request (with en=1) preempts on the next edge.
  - Result: an owner holds for exactly MAX_HOLD cycles when contended.
- preempt is 0 on every cycle except the first cycle of a timeout-induced grant.
- en=0 never removes an existing grant. It only blocks new grants and handoffs.
- Simultaneous owner release and competing request: handled as a handoff, not as idle.
- Simultaneous requests from IDLE: the lowest index at or after ptr+1 (mod 16) wins.
- req is sampled only at clock edges. Glitches between edges are ignored.

Test Plan:
- Basic grant:
  - rst for 2 cycles, then req=0x0001.
  - Required: one edge later gnt=0x0001, gnt_idx=0, gnt_valid=1, preempt=0.
  - Drop req: next edge gnt=0, gnt_valid=0.
- Handoff and wrap:
  - From reset, req=0x8001 → grant idx 0.
  - req=0x8000 → next edge idx 15, gnt=0x8000, with no idle cycle.
  - req=0 → idle.
  - req=0x8001 → grant idx 0 (search wraps from ptr=15).
- Timeout rotation:
  - MAX_HOLD=8, req=0x0006 held constant from idle.
  - Required: idx 1 for 8 cycles, then idx 2 with preempt=1 for one cycle, idx 2 for 8 cycles, then idx 1 with preempt=1.
  - Pattern repeats. gnt never 0 after the first grant.
- Uncontended hold:
  - req=0x0010 held for 20 cycles.
  - Required: gnt=0x0010 throughout, preempt=0, cnt saturates.
  - Then req=0x0011: next edge idx 0 with preempt=1.
- Enable gating:
  - en=0, req=0xFFFF from idle for 5 cycles → gnt_valid=0.
  - Set en=1 → next edge idx 0.
  - Set en=0 while owner 0 holds → grant kept past MAX_HOLD, no preempt.
  - Release req[0] with en=0 → IDLE.
- Reset mid-operation:
  - Assert rst while idx 5 is granted.
  - Required: next edge all outputs 0.
  - Deassert rst, req=0x0003 → grant idx 0 (ptr restored to 15).
